control_layer_gen: RTL and testbench

Parametrised layer controller for VGG16 conv layers, generalising the fixed layer-1 control chain. It walks a zero-padded raster frame of any size, requests input pixels only at interior positions, and drives padding strobes and position counters. It flags complete KSIZE×KSIZE windows and propagates window validity through configurable conv-pipeline and bias-pipeline depths. It repeats the frame NUM_PASS times (output-channel groups) and signals layer completion. Sits between the feature-map line buffer/padding datapath and the conv2D + bias/ReLU datapath.

---
 rtl/control_layer_gen.sv | 128 ++++++++++++
 tb/tb_control_layer_gen.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/control_layer_gen.sv
// rtl/control_layer_gen.sv - padded-raster layer controller with window-valid pipelines
module control_layer_gen #(
  parameter int WIDTH    = 5,
  parameter int HEIGHT   = 5,
  parameter int PAD      = 1,
  parameter int KSIZE    = 3,
  parameter int CONV_LAT = 4,
  parameter int BIAS_LAT = 2,
  parameter int NUM_PASS = 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic                valid_in,
  output logic                in_ready,
  output logic                padding_valid,
  output logic [31:0]         counter_col,
  output logic [31:0]         counter_row,
  output logic [31:0]         pass_idx,
  output logic                window_valid,
  output logic [CONV_LAT-1:0] valid_pipeline2D,
  output logic [BIAS_LAT-1:0] valid_pipeline_bias,
  output logic                valid_out,
  output logic                busy,
  output logic                layer_done
);

  localparam logic [31:0] PW         = 32'(WIDTH + 2 * PAD);
  localparam logic [31:0] PH         = 32'(HEIGHT + 2 * PAD);
  localparam logic [31:0] LO         = 32'(PAD);
  localparam logic [31:0] COL_HI     = 32'(PAD + WIDTH);
  localparam logic [31:0] ROW_HI     = 32'(PAD + HEIGHT);
  localparam logic [31:0] K_LAST     = 32'(KSIZE - 1);
  localparam logic [31:0] DRAIN_LAST = 32'(CONV_LAT + BIAS_LAT - 1);
  localparam logic [31:0] PASS_LAST  = 32'(NUM_PASS - 1);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

  state_t      state, state_nx;
  logic [31:0] col_nx, row_nx, pass_nx, drain_cnt, drain_nx;
  logic        done_nx, is_pad, advance;

  assign busy      = (state != IDLE);
  assign valid_out = valid_pipeline_bias[BIAS_LAT-1];

  always_comb begin
    state_nx      = state;
    col_nx        = counter_col;
    row_nx        = counter_row;
    pass_nx       = pass_idx;
    drain_nx      = drain_cnt;
    done_nx       = 1'b0;
    in_ready      = 1'b0;
    padding_valid = 1'b0;
    advance       = 1'b0;
    window_valid  = 1'b0;
    is_pad = (counter_row < LO) || (counter_row >= ROW_HI) ||
             (counter_col < LO) || (counter_col >= COL_HI);
    unique case (state)
      IDLE: begin
        pass_nx = 32'd0;
        if (start) state_nx = RUN;
      end
      RUN: begin
        padding_valid = is_pad;
        in_ready      = !is_pad;
        // Pad positions never wait on the upstream pixel stream.
        advance       = is_pad || valid_in;
        window_valid  = advance && (counter_row >= K_LAST) && (counter_col >= K_LAST);
        if (advance) begin
          if (counter_col == PW - 32'd1) begin
            col_nx = 32'd0;
            if (counter_row == PH - 32'd1) begin
              row_nx   = 32'd0;
              drain_nx = 32'd0;
              state_nx = DRAIN;
            end else begin
              row_nx = counter_row + 32'd1;
            end
          end else begin
            col_nx = counter_col + 32'd1;
          end
        end
      end
      DRAIN: begin
        if (drain_cnt == DRAIN_LAST) begin
          drain_nx = 32'd0;
          if (pass_idx == PASS_LAST) begin
            state_nx = IDLE;
            pass_nx  = 32'd0;
            done_nx  = 1'b1;
          end else begin
            state_nx = RUN;
            pass_nx  = pass_idx + 32'd1;
          end
        end else begin
          drain_nx = drain_cnt + 32'd1;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state               <= IDLE;
      counter_col         <= 32'd0;
      counter_row         <= 32'd0;
      pass_idx            <= 32'd0;
      drain_cnt           <= 32'd0;
      layer_done          <= 1'b0;
      valid_pipeline2D    <= '0;
      valid_pipeline_bias <= '0;
    end else begin
      state       <= state_nx;
      counter_col <= col_nx;
      counter_row <= row_nx;
      pass_idx    <= pass_nx;
      drain_cnt   <= drain_nx;
      layer_done  <= done_nx;
      valid_pipeline2D[0]    <= window_valid;
      valid_pipeline_bias[0] <= valid_pipeline2D[CONV_LAT-1];
      for (int i = 1; i < CONV_LAT; i++) valid_pipeline2D[i] <= valid_pipeline2D[i-1];
      for (int i = 1; i < BIAS_LAT; i++) valid_pipeline_bias[i] <= valid_pipeline_bias[i-1];
    end
  end

endmodule

// File: tb/tb_control_layer_gen.sv
// tb/tb_control_layer_gen.sv - scoreboard bench for control_layer_gen
module tb_control_layer_gen;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [2:0]  start_v = 3'b000;
  logic        valid_in = 1'b0;
  logic        ir[3], pv[3], wv[3], vo[3], bz[3], ld[3];
  logic [31:0] cc[3], cr[3], pi[3];
  logic [3:0]  p2a, p2b;
  logic [1:0]  pba, pbb, p2c;
  logic [0:0]  pbc;
  int          vectors = 0;
  int          errors = 0;

  always #5 clk = ~clk;

  control_layer_gen dut_a (
    .clk(clk), .rst(rst), .start(start_v[0]), .valid_in(valid_in),
    .in_ready(ir[0]), .padding_valid(pv[0]), .counter_col(cc[0]), .counter_row(cr[0]),
    .pass_idx(pi[0]), .window_valid(wv[0]), .valid_pipeline2D(p2a),
    .valid_pipeline_bias(pba), .valid_out(vo[0]), .busy(bz[0]), .layer_done(ld[0]));

  control_layer_gen #(.NUM_PASS(3)) dut_b (
    .clk(clk), .rst(rst), .start(start_v[1]), .valid_in(valid_in),
    .in_ready(ir[1]), .padding_valid(pv[1]), .counter_col(cc[1]), .counter_row(cr[1]),
    .pass_idx(pi[1]), .window_valid(wv[1]), .valid_pipeline2D(p2b),
    .valid_pipeline_bias(pbb), .valid_out(vo[1]), .busy(bz[1]), .layer_done(ld[1]));

  control_layer_gen #(.WIDTH(8), .HEIGHT(4), .PAD(0), .KSIZE(3), .CONV_LAT(2), .BIAS_LAT(1)) dut_c (
    .clk(clk), .rst(rst), .start(start_v[2]), .valid_in(valid_in),
    .in_ready(ir[2]), .padding_valid(pv[2]), .counter_col(cc[2]), .counter_row(cr[2]),
    .pass_idx(pi[2]), .window_valid(wv[2]), .valid_pipeline2D(p2c),
    .valid_pipeline_bias(pbc), .valid_out(vo[2]), .busy(bz[2]), .layer_done(ld[2]));

  // Independent behavioural model of one layer; expected valid_out times go to a queue.
  task automatic run_layer(input int s, input int w, input int h, input int p, input int k,
                           input int l, input int np, input bit toggle);
    int pw, ph, st, col, row, pas, dcnt, wins, outs, cons, dones, exp_w;
    int q[$];
    bit pad, adv, win, exp_vo, exp_ld, fin;
    logic [5:0] got_b, exp_b;
    logic [95:0] got_c, exp_c;
    pw = w + 2 * p; ph = h + 2 * p;
    st = 0; col = 0; row = 0; pas = 0; dcnt = 0;
    wins = 0; outs = 0; cons = 0; dones = 0; exp_ld = 0; fin = 0;
    exp_w = (ph - k + 1) * (pw - k + 1) * np;
    for (int cyc = 0; cyc < 3000 && !fin; cyc++) begin
      @(posedge clk); #1;
      start_v[s] = (cyc == 0) || (cyc == 10);
      valid_in   = toggle ? ((cyc % 2) == 1) : 1'b1;
      @(negedge clk);
      pad = (st == 1) && (row < p || row >= p + h || col < p || col >= p + w);
      adv = (st == 1) && (pad || valid_in);
      win = adv && row >= k - 1 && col >= k - 1;
      exp_vo = (q.size() > 0) && (q[0] == cyc);
      if (exp_vo) void'(q.pop_front());
      exp_b = {(st == 1) && !pad, pad, win, exp_vo, st != 0, exp_ld};
      got_b = {ir[s], pv[s], wv[s], vo[s], bz[s], ld[s]};
      vectors++;
      if (got_b !== exp_b) begin
        errors++;
        $display("FAIL flags dut%0d cyc=%0d got %b expected %b (ir,pv,wv,vo,busy,done)", s, cyc, got_b, exp_b);
      end
      exp_c = {32'(col), 32'(row), 32'(pas)};
      got_c = {cc[s], cr[s], pi[s]};
      vectors++;
      if (got_c !== exp_c) begin
        errors++;
        $display("FAIL counters dut%0d cyc=%0d got col=%0d row=%0d pass=%0d expected col=%0d row=%0d pass=%0d",
                 s, cyc, cc[s], cr[s], pi[s], col, row, pas);
      end
      if (wv[s]) wins++;
      if (vo[s]) outs++;
      if (ir[s] && valid_in) cons++;
      if (ld[s]) dones++;
      if (exp_ld) fin = 1;
      if (win) q.push_back(cyc + l);
      exp_ld = 0;
      case (st)
        0: if (start_v[s]) st = 1;
        1: if (adv) begin
             if (col == pw - 1) begin
               col = 0;
               if (row == ph - 1) begin row = 0; st = 2; dcnt = 0; end
               else row++;
             end else col++;
           end
        default: if (dcnt == l - 1) begin
             dcnt = 0;
             if (pas == np - 1) begin st = 0; pas = 0; exp_ld = 1; end
             else begin pas++; st = 1; end
           end else dcnt++;
      endcase
    end
    start_v[s] = 1'b0;
    vectors++;
    if (!fin) begin errors++; $display("FAIL timeout dut%0d got no layer_done expected one", s); end
    vectors++;
    if (wins != exp_w || outs != exp_w) begin
      errors++;
      $display("FAIL window_count dut%0d got win=%0d out=%0d expected %0d", s, wins, outs, exp_w);
    end
    vectors++;
    if (cons != w * h * np) begin
      errors++;
      $display("FAIL consumptions dut%0d got %0d expected %0d", s, cons, w * h * np);
    end
    vectors++;
    if (dones != 1 || q.size() != 0) begin
      errors++;
      $display("FAIL done_count dut%0d got dones=%0d pending=%0d expected 1 and 0", s, dones, q.size());
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    for (int s = 0; s < 3; s++) begin
      vectors++;
      if ({ir[s], pv[s], wv[s], vo[s], bz[s], ld[s], cc[s], cr[s], pi[s]} !== '0) begin
        errors++;
        $display("FAIL reset_state dut%0d got nonzero outputs expected all 0", s);
      end
    end
    vectors++;
    if ({p2a, pba, p2b, pbb, p2c, pbc} !== '0) begin
      errors++;
      $display("FAIL reset_pipes got %b expected 0", {p2a, pba, p2b, pbb, p2c, pbc});
    end
    @(posedge clk); #1 rst = 1'b0;
  endtask

  task automatic test_basic();     run_layer(0, 5, 5, 1, 3, 6, 1, 1'b0); endtask
  task automatic test_stall();     run_layer(0, 5, 5, 1, 3, 6, 1, 1'b1); endtask
  task automatic test_multipass(); run_layer(1, 5, 5, 1, 3, 6, 3, 1'b0); endtask
  task automatic test_nopad();     run_layer(2, 8, 4, 0, 3, 3, 1, 1'b0); endtask

  task automatic test_reset_mid();
    bit found;
    found = 0;
    valid_in = 1'b1;
    @(posedge clk); #1 start_v[0] = 1'b1;
    @(posedge clk); #1 start_v[0] = 1'b0;
    for (int i = 0; i < 100 && !found; i++) begin
      @(negedge clk);
      if (cr[0] == 32'd3 && cc[0] == 32'd2) found = 1;
    end
    vectors++;
    if (!found) begin errors++; $display("FAIL reach_r3c2 got no such position expected row 3 col 2"); end
    rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    vectors++;
    if ({ir[0], pv[0], wv[0], vo[0], bz[0], ld[0], cc[0], cr[0], pi[0], p2a, pba} !== '0) begin
      errors++;
      $display("FAIL mid_reset got busy=%b col=%0d row=%0d pipes=%b expected all 0", bz[0], cc[0], cr[0], {p2a, pba});
    end
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      vectors++;
      if ({vo[0], ld[0], bz[0]} !== 3'b000) begin
        errors++;
        $display("FAIL post_reset cyc=%0d got vo,done,busy=%b expected 000", i, {vo[0], ld[0], bz[0]});
      end
    end
  endtask

  task automatic test_start_rst();
    @(posedge clk); #1;
    rst = 1'b1; start_v[0] = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0; start_v[0] = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      vectors++;
      if ({bz[0], cc[0], cr[0], pi[0]} !== '0) begin
        errors++;
        $display("FAIL start_with_rst cyc=%0d got busy=%b col=%0d row=%0d expected idle", i, bz[0], cc[0], cr[0]);
      end
    end
    run_layer(0, 5, 5, 1, 3, 6, 1, 1'b0);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_stall();
    test_multipass();
    test_nopad();
    test_reset_mid();
    test_start_rst();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
